dec_seq_ctrl: RTL and testbench
===============================

Name: dec_seq_ctrl

Overview:
Sequencing controller wrapped around the combinational decode datapath (syndrome plus output/flip stage). It accepts codewords over a valid/ready handshake and holds each codeword stable on the datapath for DP_LAT cycles. It then samples the corrected data and error classification, and presents them downstream over a second valid/ready handshake. It also keeps saturating per-class error statistics for the status register block.

Parameters:
DATA_WIDTH, 16, codeword/data width in bits; legal range 4..32.
DP_LAT, 1, cycles the datapath needs after dp_codeword changes before its outputs are valid; legal range 1..7.
CNT_WIDTH, 16, width of each statistics counter.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  upstream codeword valid.
in_ready  output  1  controller can accept a codeword this cycle.
in_codeword  input  DATA_WIDTH  received codeword.
dp_codeword  output  DATA_WIDTH  registered codeword driven into the decode datapath.
dp_num_of_errors  input  2  datapath classification: 00 none, 01 single (corrected), 10 double (uncorrectable), 11 illegal.
dp_data  input  DATA_WIDTH  datapath data; is Z when the classification is 10.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
data_out  output  DATA_WIDTH  registered decoded data.
num_of_errors  output  2  registered classification.
clr_counters  input  1  synchronous clear of the statistics.
cnt_single  output  CNT_WIDTH  count of 01 results.
cnt_double  output  CNT_WIDTH  count of 10 and 11 results.
err_illegal  output  1  sticky flag: a classification of 11 was seen; cleared by rst or clr_counters.

Behaviour:
- Reset (rst=1 at an edge): state IDLE, lat_cnt=0, dp_codeword=0, data_out=0, num_of_errors=00, out_valid=0, counters=0, err_illegal=0. Reset wins over every other event; an in-flight transaction is dropped silently.
- State machine: states IDLE, WAIT, HOLD.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: dp_codeword<=in_codeword, lat_cnt<=DP_LAT-1, go to WAIT.
- WAIT:
  - in_ready=0. dp_codeword stays stable.
  - If lat_cnt!=0: decrement lat_cnt.
  - If lat_cnt==0, sample:
    - num_of_errors<=dp_num_of_errors.
    - data_out<=dp_data for 00/01; data_out<=0 for 10/11, so Z/X is never registered.
    - out_valid<=1, go to HOLD.
- Latency: codeword accepted at edge T; result sampled at edge T+DP_LAT; out_valid is high from cycle T+DP_LAT.
- HOLD:
  - out_valid=1. data_out and num_of_errors are held stable until out_ready=1.
  - in_ready = out_ready (combinational pass-through).
  - out_ready=1 and in_valid=1: the result retires and the new codeword is captured in the same edge; go to WAIT (back-to-back; throughput one result per DP_LAT+1 cycles).
  - out_ready=1 and in_valid=0: out_valid<=0, go to IDLE.
- Statistics, updated at the sample edge only (once per transaction, never during HOLD stalls):
  - 01 increments cnt_single.
  - 10 or 11 increments cnt_double.
  - 11 also sets err_illegal.
  - Counters saturate at all-ones; no wrap.
  - clr_counters at the same edge as an increment: clear wins, and the result reads 0.
- Output registers are not affected by clr_counters.
- in_codeword is ignored whenever in_ready=0.

Decomposition:
- Package dec_ctrl_pkg:
  - state enum (IDLE, WAIT, HOLD);
  - error codes ERR_NONE=2'b00, ERR_SINGLE=2'b01, ERR_DOUBLE=2'b10, ERR_ILLEGAL=2'b11.
- Sub-module dec_sat_counter:
  - parameter WIDTH; ports clk, rst, clr, inc, count;
  - saturating, with clr priority over inc;
  - instantiated twice.
- The datapath itself is not instantiated inside this block; it is connected at the parent level.

Test Plan:
- DP_LAT=1; accept 16'hA5A5 with the datapath model returning 00 / 16'h00A5, out_ready=1 -> out_valid high exactly 1 cycle after acceptance; data_out=16'h00A5, num_of_errors=00; counters unchanged.
- DP_LAT=3; single-error codeword, model returns 01 / 16'h1234; out_ready held 0 for 5 cycles -> out_valid from T+3; outputs stable through the stall; cnt_single=1 (not 6); in_ready=0 throughout.
- Model returns 10 with dp_data=Z -> data_out=16'h0000, num_of_errors=10, cnt_double=1. Model returns 11 -> cnt_double=2, err_illegal=1.
- Back-to-back: in_valid and out_ready held high for 4 codewords, DP_LAT=1 -> one result every 2 cycles, in order, no loss or duplication.
- CNT_WIDTH=2; 5 single-error results -> cnt_single saturates at 3. clr_counters coincident with a 6th single-error sample -> cnt_single=0.
- rst asserted during WAIT, then in HOLD -> next cycle out_valid=0, in_ready=1, all outputs at reset values; no counter increments from the dropped transactions.

Source files
------------

// File: rtl/dec_seq_ctrl_pkg.sv
// Shared types and error-classification codes for the decode sequencing controller.
package dec_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_SINGLE  = 2'b01;
    localparam logic [1:0] ERR_DOUBLE  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    // Both 10 and 11 mean the datapath data bus carries nothing trustworthy.
    function automatic logic is_uncorrectable(input logic [1:0] cls);
        return cls[1];
    endfunction

endpackage

// File: rtl/dec_seq_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module dec_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/dec_seq_ctrl.sv
// Sequencer around the combinational decode datapath: holds each codeword for DP_LAT
// cycles, registers the result behind a valid/ready handshake and keeps error statistics.
module dec_seq_ctrl
    import dec_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DP_LAT     = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_codeword,
    output logic [DATA_WIDTH-1:0] dp_codeword,
    input  logic [1:0]            dp_num_of_errors,
    input  logic [DATA_WIDTH-1:0] dp_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            num_of_errors,
    input  logic                  clr_counters,
    output logic [CNT_WIDTH-1:0]  cnt_single,
    output logic [CNT_WIDTH-1:0]  cnt_double,
    output logic                  err_illegal
);

    localparam logic [2:0] LAT_LOAD = 3'(DP_LAT - 1);

    state_e                r_state;
    state_e                w_next_state;
    logic [2:0]            r_lat_cnt;
    logic [DATA_WIDTH-1:0] r_dp_codeword;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic [1:0]            r_num_of_errors;
    logic                  r_out_valid;
    logic                  r_err_illegal;

    logic w_in_ready;
    logic w_accept;
    logic w_sample;
    logic w_inc_single;
    logic w_inc_double;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_accept     = 1'b0;
        w_sample     = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (r_lat_cnt == 3'd0) begin
                    w_sample     = 1'b1;
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                // A retiring result frees the slot in the same cycle.
                w_in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_accept     = 1'b1;
                        w_next_state = WAIT;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lat_cnt       <= 3'd0;
            r_dp_codeword   <= '0;
            r_data_out      <= '0;
            r_num_of_errors <= ERR_NONE;
            r_out_valid     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dp_codeword <= in_codeword;
                r_lat_cnt     <= LAT_LOAD;
            end else if ((r_state == WAIT) && (r_lat_cnt != 3'd0)) begin
                r_lat_cnt <= r_lat_cnt - 3'd1;
            end

            // Uncorrectable results register zero so a floating bus is never captured.
            if (w_sample) begin
                r_num_of_errors <= dp_num_of_errors;
                r_data_out      <= is_uncorrectable(dp_num_of_errors) ? '0 : dp_data;
                r_out_valid     <= 1'b1;
            end else if ((r_state == HOLD) && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign w_inc_single = w_sample && (dp_num_of_errors == ERR_SINGLE);
    assign w_inc_double = w_sample && is_uncorrectable(dp_num_of_errors);

    always_ff @(posedge clk) begin
        if (rst || clr_counters) begin
            r_err_illegal <= 1'b0;
        end else if (w_sample && (dp_num_of_errors == ERR_ILLEGAL)) begin
            r_err_illegal <= 1'b1;
        end
    end

    dec_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_cnt_single (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_counters),
        .inc   (w_inc_single),
        .count (cnt_single)
    );

    dec_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_cnt_double (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_counters),
        .inc   (w_inc_double),
        .count (cnt_double)
    );

    assign in_ready      = w_in_ready;
    assign dp_codeword   = r_dp_codeword;
    assign out_valid     = r_out_valid;
    assign data_out      = r_data_out;
    assign num_of_errors = r_num_of_errors;
    assign err_illegal   = r_err_illegal;

endmodule

// File: tb/tb_dec_seq_ctrl.sv
// Randomized scoreboard bench: two controller instances (DP_LAT=1/CNT_WIDTH=16 and
// DP_LAT=3/CNT_WIDTH=2), each with its own latency-aware datapath model, driver and monitor.
module tb_dec_seq_ctrl;

    localparam int DW   = 16;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic [DW-1:0] cw;
        logic [DW-1:0] data;
        logic [1:0]    cls;
        int            acc;
        int            smp;
    } exp_t;

    function automatic logic [1:0] ref_class(input logic [DW-1:0] cw);
        return cw[1:0] ^ cw[5:4];
    endfunction

    function automatic logic [DW-1:0] ref_dp_data(input logic [DW-1:0] cw);
        case (ref_class(cw))
            2'b00:   return cw ^ 16'hC3C3;
            2'b01:   return cw ^ 16'h3C3C;
            2'b10:   return 'z;
            default: return 16'hDEAD;
        endcase
    endfunction

    function automatic logic [DW-1:0] ref_out_data(input logic [DW-1:0] cw);
        return ref_class(cw)[1] ? '0 : ref_dp_data(cw);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_env
        localparam int LAT     = (g == 0) ? 1 : 3;
        localparam int CW      = (g == 0) ? 16 : 2;
        localparam int CNT_MAX = (1 << CW) - 1;

        logic          rst, in_valid, in_ready, out_valid, out_ready, clr, err_illegal;
        logic [DW-1:0] in_cw, dp_cw, dp_data, data_out;
        logic [1:0]    dp_num, num_out;
        logic [CW-1:0] cnt_single, cnt_double;
        logic          done = 1'b0;
        int            cyc  = 0;
        exp_t          q[$];

        dec_seq_ctrl #(
            .DATA_WIDTH (DW),
            .DP_LAT     (LAT),
            .CNT_WIDTH  (CW)
        ) u_dut (
            .clk              (clk),
            .rst              (rst),
            .in_valid         (in_valid),
            .in_ready         (in_ready),
            .in_codeword      (in_cw),
            .dp_codeword      (dp_cw),
            .dp_num_of_errors (dp_num),
            .dp_data          (dp_data),
            .out_valid        (out_valid),
            .out_ready        (out_ready),
            .data_out         (data_out),
            .num_of_errors    (num_out),
            .clr_counters     (clr),
            .cnt_single       (cnt_single),
            .cnt_double       (cnt_double),
            .err_illegal      (err_illegal)
        );

        always @(posedge clk) cyc <= cyc + 1;

        // Datapath model: answers are wrong until the codeword has been stable LAT cycles.
        logic [DW-1:0] dp_prev;
        int            age = 0;
        always @(negedge clk) begin
            if (dp_cw !== dp_prev) age = 1;
            else if (age < 100) age++;
            dp_prev = dp_cw;
            if (age >= LAT) begin
                dp_num  = ref_class(dp_cw);
                dp_data = ref_dp_data(dp_cw);
            end else begin
                dp_num  = ~ref_class(dp_cw);
                dp_data = dp_cw ^ 16'hFFFF;
            end
        end

        // Driver: random handshakes, clears and resets; pushes expectations on acceptance.
        initial begin
            exp_t e;
            rst       = 1'b1;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            clr       = 1'b0;
            in_cw     = '0;
            @(negedge clk);
            for (int i = 0; i < NCYC; i++) begin
                @(negedge clk);
                rst       = ($urandom_range(0, 149) == 0);
                clr       = ($urandom_range(0, 29) == 0);
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 6);
                in_cw     = DW'($urandom);
                #1;
                if (in_valid && in_ready) begin
                    e.cw   = in_cw;
                    e.cls  = ref_class(in_cw);
                    e.data = ref_out_data(in_cw);
                    e.acc  = cyc + 1;
                    e.smp  = cyc + 1 + LAT;
                    q.push_back(e);
                end
            end
            @(negedge clk);
            rst       = 1'b0;
            clr       = 1'b0;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            repeat (LAT + 4) @(negedge clk);
            done = 1'b1;
        end

        // Monitor: reference statistics and output expectations per clock edge.
        int            last_rst  = 1;
        int            last_clr  = 0;
        int            m_single  = 0;
        int            m_double  = 0;
        logic          m_illegal = 1'b0;
        logic [DW-1:0] m_dp_cw   = '0;
        logic          hv, hs;

        always @(negedge clk) begin
            #2;
            if (last_rst != 0) begin
                while ((q.size() > 0) && (q[0].acc <= cyc)) q.delete(0);
                m_single  = 0;
                m_double  = 0;
                m_illegal = 1'b0;
                m_dp_cw   = '0;
            end else begin
                foreach (q[k]) begin
                    if (q[k].acc == cyc) m_dp_cw = q[k].cw;
                    if ((q[k].smp == cyc) && (last_clr == 0)) begin
                        if (q[k].cls == 2'b01 && m_single < CNT_MAX) m_single++;
                        if (q[k].cls[1] && m_double < CNT_MAX) m_double++;
                        if (q[k].cls == 2'b11) m_illegal = 1'b1;
                    end
                end
                if (last_clr != 0) begin
                    m_single  = 0;
                    m_double  = 0;
                    m_illegal = 1'b0;
                end
            end

            hv = (q.size() > 0) && (q[0].acc <= cyc);
            hs = hv && (q[0].smp <= cyc);
            check($sformatf("env%0d out_valid", g), 32'(out_valid), 32'(hs));
            if (hs) begin
                check($sformatf("env%0d data_out", g), 32'(data_out), 32'(q[0].data));
                check($sformatf("env%0d num_of_errors", g), 32'(num_out), 32'(q[0].cls));
            end else if (last_rst != 0) begin
                check($sformatf("env%0d data_out after reset", g), 32'(data_out), 32'd0);
                check($sformatf("env%0d num_of_errors after reset", g), 32'(num_out), 32'd0);
            end
            check($sformatf("env%0d dp_codeword", g), 32'(dp_cw), 32'(m_dp_cw));
            check($sformatf("env%0d cnt_single", g), 32'(cnt_single), 32'(m_single));
            check($sformatf("env%0d cnt_double", g), 32'(cnt_double), 32'(m_double));
            check($sformatf("env%0d err_illegal", g), 32'(err_illegal), 32'(m_illegal));
            check($sformatf("env%0d in_ready", g), 32'(in_ready),
                  32'(!hv ? 1'b1 : (hs ? out_ready : 1'b0)));
            if (hs && out_ready) q.delete(0);
            last_rst = int'(rst);
            last_clr = int'(clr);
        end
    end

    initial begin
        for (int t = 0; t < 20000; t++) begin
            @(posedge clk);
            if (g_env[0].done && g_env[1].done) break;
        end
        if (!(g_env[0].done && g_env[1].done)) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL timeout: drivers did not complete, got done=%0b%0b expected 11",
                     g_env[1].done, g_env[0].done);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
